ofm_readback: RTL and testbench

- Streams the finished output feature map out of the OFM DPRAM to a host-side consumer. It is the read end of the path that the conv/maxpool/upsample datapath fills.
- Sits beside `dpram_ofm` and uses its second port once TOP asserts `done`.
- Reads the memory linearly: channel-major, then row, then column, matching the write order.
- Emits `INOUT_WIDTH`-bit beats over a valid/ready stream, with a last marker on the final beat.

---
 rtl/ofm_readback_pkg.sv | 28 ++
 rtl/ofm_rd_fifo.sv | 50 +++++
 rtl/ofm_readback.sv | 124 ++++++++++++
 tb/tb_ofm_readback.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_readback_pkg.sv
// Shared definitions for the OFM readback path: geometry helpers and FSM state encoding.
package ofm_readback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int elems_per_word(input int data_width, input int inout_width);
        return inout_width / (2 * data_width);
    endfunction

    function automatic int total_elems(input int ofm_size, input int no_filter);
        return ofm_size * ofm_size * no_filter;
    endfunction

endpackage

// File: rtl/ofm_rd_fifo.sv
// Two-entry skid FIFO between the DPRAM read port and the output stream.
module ofm_rd_fifo #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push   = push && ((count_reg != 2'd2) || pop);
    assign do_pop    = pop && (count_reg != 2'd0);
    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ofm_readback.sv
// Streams the finished OFM out of the DPRAM second port as a valid/ready beat stream
// with a last marker, reading words linearly in write order.
module ofm_readback #(
    parameter int DATA_WIDTH  = 8,
    parameter int INOUT_WIDTH = 128,
    parameter int OFM_SIZE    = 26,
    parameter int NO_FILTER   = 128,
    parameter int ADDR_WIDTH  = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [INOUT_WIDTH-1:0] rd_data,
    output logic [INOUT_WIDTH-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done
);
    import ofm_readback_pkg::*;

    localparam int ELEMS_PER_WORD = elems_per_word(DATA_WIDTH, INOUT_WIDTH);
    localparam int TOTAL_ELEMS    = total_elems(OFM_SIZE, NO_FILTER);
    localparam int TOTAL_WORDS    = TOTAL_ELEMS / ELEMS_PER_WORD;
    localparam int CNT_W          = clog2(TOTAL_WORDS + 1);
    localparam logic [CNT_W-1:0] END_CNT   = CNT_W'(TOTAL_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOTAL_WORDS - 1);

    if ((TOTAL_ELEMS % ELEMS_PER_WORD) != 0) begin : g_bad_geometry
        $error("ofm_readback: OFM element count is not a whole number of words");
    end
    if ((64'd1 << ADDR_WIDTH) < 64'(TOTAL_WORDS)) begin : g_bad_addr
        $error("ofm_readback: ADDR_WIDTH too small for the OFM word count");
    end

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] rd_cnt_reg;
    logic [CNT_W-1:0] beat_cnt_reg;
    logic             inflight_reg;
    logic [1:0]       fifo_count;
    logic [2:0]       occupancy;
    logic             pop;

    assign pop     = m_valid && m_ready;
    // Words held or already requested, net of the beat leaving this cycle.
    assign occupancy = 3'(fifo_count) + 3'(inflight_reg) - 3'(pop);
    assign rd_addr = ADDR_WIDTH'(rd_cnt_reg);
    assign m_valid = (fifo_count != 2'd0);
    assign m_last  = m_valid && (beat_cnt_reg == LAST_BEAT);

    ofm_rd_fifo #(
        .WIDTH(INOUT_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_reg),
        .push_data (rd_data),
        .pop       (pop),
        .head_data (m_data),
        .count     (fifo_count)
    );

    always_comb begin
        state_next = state_reg;
        rd_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (rd_cnt_reg == END_CNT) begin
                    state_next = ST_DRAIN;
                end else if (occupancy < 3'd2) begin
                    rd_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // All reads are issued; the accepted last beat leaves nothing behind.
                if (pop && m_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rd_cnt_reg   <= '0;
            beat_cnt_reg <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= rd_en;
            if ((state_reg == ST_IDLE) && start) begin
                rd_cnt_reg   <= '0;
                beat_cnt_reg <= '0;
            end else begin
                if (rd_en) begin
                    rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
                end
                if (pop) begin
                    beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ofm_readback.sv
// Scoreboard bench for ofm_readback: default geometry plus a 2-word configuration.
module tb_ofm_readback;
    localparam int TW   = 10816;
    localparam int AW   = 14;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } beat_t;

    logic         clk;
    logic         rst_n;
    logic         start, rd_en, m_valid, m_ready, m_last, busy, done;
    logic [AW-1:0] rd_addr;
    logic [127:0] rd_data, m_data;
    logic         s_start, s_rd_en, s_m_valid, s_m_ready, s_m_last, s_busy, s_done;
    logic [AW-1:0] s_rd_addr;
    logic [127:0] s_rd_data, s_m_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pat_sel = 0;
    beat_t exp_q[$];
    beat_t s_exp_q[$];
    beat_t b, sb;
    int exp_addr, rd_en_cnt, beat_seen, first_rd, first_v, done_cnt, done_cyc, last_cyc, start_cyc;
    int s_beats, s_done_cnt, s_done_cyc, s_start_cyc;

    ofm_readback u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .done(done)
    );

    ofm_readback #(.OFM_SIZE(2), .NO_FILTER(4)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
        .rd_data(s_rd_data), .m_data(s_m_data), .m_valid(s_m_valid), .m_ready(s_m_ready),
        .m_last(s_m_last), .busy(s_busy), .done(s_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pattern 0: every element of word n is n[15:0]; pattern 1: element i = i*7+3.
    function automatic logic [127:0] word_of(input int n, input int sel);
        logic [127:0] w;
        logic [31:0]  nv;
        logic [31:0]  ev;
        nv = n;
        w  = '0;
        for (int k = 0; k < 8; k++) begin
            ev = (sel == 0) ? nv : ((nv * 32'd8 + 32'(k)) * 32'd7 + 32'd3);
            w[16*k +: 16] = ev[15:0];
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= word_of(int'(rd_addr), pat_sel);
        if (s_rd_en) s_rd_data <= word_of(int'(s_rd_addr), 0);
    end

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, expv);
        end
    endtask

    // Main-DUT monitor: address order, beat scoreboard, event timestamps.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (rd_en) begin
                checks++;
                if (int'(rd_addr) != exp_addr) begin
                    errors++;
                    $display("FAIL rd_addr got %0d expected %0d", rd_addr, exp_addr);
                end
                if (first_rd < 0) first_rd = cyc;
                exp_addr++;
                rd_en_cnt++;
            end
            if (m_valid && first_v < 0) first_v = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat %0d got %h expected none", beat_seen, m_data);
                end else begin
                    b = exp_q.pop_front();
                    if (m_data !== b.data || m_last !== b.last) begin
                        errors++;
                        $display("FAIL beat %0d got %h last %b expected %h last %b",
                                 beat_seen, m_data, m_last, b.data, b.last);
                    end
                end
                if (pat_sel == 0 && beat_seen == 5) begin
                    checks++;
                    if (m_data !== 128'h00050005000500050005000500050005) begin
                        errors++;
                        $display("FAIL beat5_const got %h expected 0005 x8", m_data);
                    end
                end
                if (pat_sel == 0 && beat_seen == TW - 1) begin
                    checks++;
                    if (m_data !== 128'h2A3F2A3F2A3F2A3F2A3F2A3F2A3F2A3F || m_last !== 1'b1) begin
                        errors++;
                        $display("FAIL final_beat_const got %h last %b expected 2A3F x8 last 1", m_data, m_last);
                    end
                end
                if (pat_sel == 1 && beat_seen == 1) begin
                    checks++;
                    if (m_data[15:0] !== 16'h003B) begin
                        errors++;
                        $display("FAIL golden_elem8 got %h expected 003b", m_data[15:0]);
                    end
                end
                if (m_last) last_cyc = cyc;
                beat_seen++;
            end
        end
    end

    // Small-configuration monitor.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (s_done) begin
                s_done_cnt++;
                s_done_cyc = cyc;
            end
            if (s_m_valid && s_m_ready) begin
                checks++;
                if (s_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL small_extra_beat got %h expected none", s_m_data);
                end else begin
                    sb = s_exp_q.pop_front();
                    if (s_m_data !== sb.data || s_m_last !== sb.last) begin
                        errors++;
                        $display("FAIL small_beat %0d got %h last %b expected %h last %b",
                                 s_beats, s_m_data, s_m_last, sb.data, sb.last);
                    end
                end
                s_beats++;
            end
        end
    end

    task automatic prepare(input int sel);
        pat_sel = sel;
        exp_q.delete();
        for (int n = 0; n < TW; n++) exp_q.push_back('{data: word_of(n, sel), last: (n == TW - 1)});
        exp_addr = 0; rd_en_cnt = 0; beat_seen = 0; first_rd = -1; first_v = -1;
        done_cnt = 0; done_cyc = -1; last_cyc = -1;
    endtask

    task automatic pulse_start(input logic ready0);
        @(posedge clk); #1;
        start = 1'b1; m_ready = ready0; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int sel, input bit rnd, input bit bp, input int restart_at);
        bit restarted;
        restarted = 1'b0;
        prepare(sel);
        pulse_start(bp ? 1'b0 : 1'b1);
        for (int c = 1; c < 4 * TW + 400 && done_cnt == 0; c++) begin
            if (bp && c == 100) begin
                chk("bp_rd_en_pulses", rd_en_cnt, 2);
                chk("bp_rd_en_low", int'(rd_en), 0);
                chk("bp_m_valid_held", int'(m_valid), 1);
            end
            m_ready = (bp && c < 100) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            start = 1'b0;
            if (restart_at >= 0 && !restarted && beat_seen >= restart_at) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        m_ready = 1'b1;
        chk("frame_done_seen", int'(done_cnt > 0), 1);
        chk("frame_beats", beat_seen, TW);
        chk("frame_queue_left", exp_q.size(), 0);
        chk("frame_reads", exp_addr, TW);
        chk("first_rd_latency", first_rd, start_cyc + 1);
        chk("first_valid_latency", first_v, first_rd + 2);
        chk("done_after_last", done_cyc, last_cyc + 1);
        chk("idle_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk("done_once", done_cnt, 1);
        chk("done_low_after", int'(done), 0);
    endtask

    task automatic s_prepare();
        s_exp_q.delete();
        s_exp_q.push_back('{data: word_of(0, 0), last: 1'b0});
        s_exp_q.push_back('{data: word_of(1, 0), last: 1'b1});
        s_beats = 0; s_done_cnt = 0; s_done_cyc = -1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; m_ready = 1'b1; s_start = 1'b0; s_m_ready = 1'b1;
        rd_data = '0; s_rd_data = '0;
        exp_addr = 0; rd_en_cnt = 0; beat_seen = 0; first_rd = -1; first_v = -1;
        done_cnt = 0; done_cyc = -1; last_cyc = -1; start_cyc = 0;
        s_beats = 0; s_done_cnt = 0; s_done_cyc = -1; s_start_cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_rd_addr", int'(rd_addr), 0);
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_m_last", int'(m_last), 0);
        chk("reset_m_data_nonzero", int'(m_data != '0), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;

        run_frame(0, 1'b0, 1'b0, -1);
        run_frame(1, 1'b1, 1'b0, -1);
        run_frame(0, 1'b0, 1'b1, 500);

        // Mid-frame reset around beat 3000, then a clean full frame.
        prepare(0);
        pulse_start(1'b1);
        for (int c = 0; c < 4 * TW && beat_seen < 3000; c++) begin
            @(posedge clk); #1;
        end
        chk("reset_point_reached", int'(beat_seen >= 3000), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset_m_valid", int'(m_valid), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_rd_addr", int'(rd_addr), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        run_frame(0, 1'b0, 1'b0, -1);

        // Small configuration: done timing and start in the done cycle.
        s_prepare();
        @(posedge clk); #1;
        s_start = 1'b1; s_start_cyc = cyc;
        @(posedge clk); #1;
        s_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("small_done_level", int'(s_done), 1);
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        chk("small_done_cycle", s_done_cyc, s_start_cyc + 1 + 4);
        chk("small_start_in_done_ignored", int'(s_busy), 0);
        chk("small_beats", s_beats, 2);
        chk("small_queue_left", s_exp_q.size(), 0);
        @(posedge clk); #1;
        chk("small_still_idle", int'(s_busy), 0);
        chk("small_done_once", s_done_cnt, 1);
        s_prepare();
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        chk("small_restart_accepted", int'(s_busy), 1);
        for (int c = 0; c < 40 && s_done_cnt == 0; c++) begin
            @(posedge clk); #1;
        end
        chk("small2_done_seen", s_done_cnt, 1);
        chk("small2_beats", s_beats, 2);
        chk("small2_queue_left", s_exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
